// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Operand width used when the parent does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Control states: wait for operands, add one bit per cycle, hold the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder stages and an OR for the carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder combines the operand bits; the second folds in the carry.
    always_comb begin
        ha0_s = a ^ b;
        ha0_c = a & b;
        s     = ha0_s ^ cin;
        ha1_c = ha0_s & cin;
        co    = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_adder_props.sv
// Checker bound into serial_adder: a presented result must equal the unsigned
// WIDTH+1-bit sum of the operands captured at the accepting edge.
module serial_adder_props #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             in_valid,
    input logic             in_ready,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             out_valid,
    input logic [WIDTH-1:0] sum,
    input logic             cout
);

    logic [WIDTH-1:0] a_cap_q;
    logic [WIDTH-1:0] b_cap_q;

    // Keep a private copy of the operands as they were on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cap_q <= '0;
            b_cap_q <= '0;
        end else if (in_valid && in_ready) begin
            a_cap_q <= a;
            b_cap_q <= b;
        end
    end

    a_sum_correct: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid |-> ({cout, sum} == ({1'b0, a_cap_q} + {1'b0, b_cap_q}))
    );

endmodule

bind serial_adder serial_adder_props #(.WIDTH(WIDTH)) u_props (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout)
);

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: accepts two WIDTH-bit operands, adds them LSB first
// over WIDTH cycles through a single full adder, then holds {cout, sum} until consumed.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             fa_s;
    logic             fa_co;

    // The single full adder always looks at the current operand LSBs and carry.
    full_adder u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Next-state and datapath logic for the three-state controller.
    always_comb begin
        // NOTE: every _d starts at its held value so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    sum_d      = '0;
                    carry_d    = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB so the first (LSB) result bit ends at bit 0.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Acceptance is only ever granted from IDLE, so in_valid is ignored here.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values
            // regardless of statement order.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule
